cern_io_pad_ctrl: RTL and testbench

CERN_IO_PAD_CTRL -- requirements
Module: cern_io_pad_ctrl

---
 rtl/cern_io_pkg.sv | 36 +++
 rtl/cern_io_pad_ctrl_if.sv | 27 ++
 rtl/cern_io_sync2.sv | 29 ++
 rtl/cern_io_pad_ctrl.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_cern_io_pad_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cern_io_pkg.sv
// cern_io_pkg -- shared types and constants for the CERN IO pad controller.
// Contents:
//   tx_state_t / rx_state_t : TX and RX state machine encodings
//   FRAME_BITS               : bits per line frame (start + 8 data + stop)
//   CLK_DIV_DEF / TURN_CYC_DEF : default bit period and bus-turnaround length
//   cnt_t / last_count()     : phase counter type and terminal-count helper
package cern_io_pkg;

  localparam int FRAME_BITS   = 10;
  localparam int CLK_DIV_DEF  = 4;
  localparam int TURN_CYC_DEF = 2;

  typedef logic [15:0] cnt_t;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_PRE   = 3'd1,
    TX_START = 3'd2,
    TX_DATA  = 3'd3,
    TX_STOP  = 3'd4,
    TX_POST  = 3'd5
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Terminal value of a phase counter that runs for n cycles starting at 0.
  function automatic cnt_t last_count(input int n);
    return cnt_t'(n - 1);
  endfunction

endpackage

// File: rtl/cern_io_pad_ctrl_if.sv
// cern_io_pad_ctrl_if -- byte-level user interface of the pad controller.
// Signals:
//   tx_data  [7:0] byte to transmit          tx_valid  transmit request
//   tx_ready       byte can be accepted      rx_data   last received byte
//   rx_valid       one-cycle received pulse  rx_err    one-cycle framing error pulse
// Modports: master = user logic, slave = pad controller.
interface cern_io_pad_ctrl_if;
  import cern_io_pkg::*;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, rx_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, rx_err
  );

endinterface

// File: rtl/cern_io_sync2.sv
// cern_io_sync2 -- two-flop synchronizer for one asynchronous input bit.
// Ports:
//   clk   : clock (rising edge)
//   rst_b : synchronous active-low reset, both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronized output
module cern_io_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cern_io_pad_ctrl.sv
// cern_io_pad_ctrl -- half-duplex single-wire serial controller for a bidirectional IO pad.
// Line: idle high, start 0, 8 data bits LSB first, stop 1, CLK_DIV cycles per bit.
// TX wraps each frame in TURN_CYC driven-high cycles before and TURN_CYC released
// cycles after. RX works on the synchronized pad input and is held idle while TX runs.
// Ports:
//   CLK, RST_B       : clock, synchronous active-low reset
//   bus (slave)      : tx_data/tx_valid/tx_ready, rx_data/rx_valid/rx_err
//   cfg_ds, cfg_pull_en, cfg_pull_up : pad configuration requests
//   PAD_Z            : asynchronous pad receiver output
//   PAD_A, PAD_OUT_EN, PAD_DS, PAD_PEN, PAD_UD_B : registered pad controls
module cern_io_pad_ctrl
  import cern_io_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int TURN_CYC = TURN_CYC_DEF
) (
  input  logic                 CLK,
  input  logic                 RST_B,
  cern_io_pad_ctrl_if.slave    bus,
  input  logic                 cfg_ds,
  input  logic                 cfg_pull_en,
  input  logic                 cfg_pull_up,
  input  logic                 PAD_Z,
  output logic                 PAD_A,
  output logic                 PAD_OUT_EN,
  output logic                 PAD_DS,
  output logic                 PAD_PEN,
  output logic                 PAD_UD_B
);

  localparam cnt_t       DIV_LAST      = last_count(CLK_DIV);
  localparam cnt_t       HALF_LAST     = last_count(CLK_DIV / 2);
  localparam cnt_t       TURN_LAST     = last_count(TURN_CYC);
  localparam logic [2:0] LAST_DATA_BIT = 3'(FRAME_BITS - 3);

  logic       pad_sync;
  logic       ready_en;
  logic       tx_ready_s;
  logic       tx_fire;

  tx_state_t  tx_state, tx_state_n;
  cnt_t       tx_cnt, tx_cnt_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic [7:0] tx_shift, tx_shift_n;
  logic       pad_a_n, pad_oe_n;

  rx_state_t  rx_state, rx_state_n;
  cnt_t       rx_cnt, rx_cnt_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_shift, rx_shift_n;
  logic       err_wait, err_wait_n;
  logic [7:0] rx_data_r, rx_data_n;
  logic       rx_valid_r, rx_valid_n;
  logic       rx_err_r, rx_err_n;

  cern_io_sync2 #(.RST_VAL(1'b1)) u_pad_sync (
    .clk   (CLK),
    .rst_b (RST_B),
    .d     (PAD_Z),
    .q     (pad_sync)
  );

  // ready_en keeps tx_ready low during reset even though the FSMs already sit in IDLE.
  assign tx_ready_s   = ready_en && (tx_state == TX_IDLE) && (rx_state == RX_IDLE) && pad_sync;
  assign tx_fire      = bus.tx_valid && tx_ready_s;
  assign bus.tx_ready = tx_ready_s;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.rx_err   = rx_err_r;

  // TX next-state: phase sequencing, bit counting and data shifting.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 16'd1;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = 16'd0;
        if (tx_fire) begin
          tx_state_n = TX_PRE;
          tx_shift_n = bus.tx_data;
          tx_bit_n   = 3'd0;
        end else begin
          tx_state_n = TX_IDLE;
        end
      end
      TX_PRE: begin
        if (tx_cnt == TURN_LAST) begin
          tx_state_n = TX_START;
          tx_cnt_n   = 16'd0;
        end else begin
          tx_state_n = TX_PRE;
        end
      end
      TX_START: begin
        if (tx_cnt == DIV_LAST) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = 16'd0;
          tx_bit_n   = 3'd0;
        end else begin
          tx_state_n = TX_START;
        end
      end
      TX_DATA: begin
        if (tx_cnt == DIV_LAST) begin
          tx_cnt_n   = 16'd0;
          tx_shift_n = {1'b0, tx_shift[7:1]};
          if (tx_bit == LAST_DATA_BIT) begin
            tx_state_n = TX_STOP;
          end else begin
            tx_bit_n = tx_bit + 3'd1;
          end
        end else begin
          tx_state_n = TX_DATA;
        end
      end
      TX_STOP: begin
        if (tx_cnt == DIV_LAST) begin
          tx_state_n = TX_POST;
          tx_cnt_n   = 16'd0;
        end else begin
          tx_state_n = TX_STOP;
        end
      end
      TX_POST: begin
        if (tx_cnt == TURN_LAST) begin
          tx_state_n = TX_IDLE;
          tx_cnt_n   = 16'd0;
        end else begin
          tx_state_n = TX_POST;
        end
      end
      default: begin
        tx_state_n = TX_IDLE;
        tx_cnt_n   = 16'd0;
      end
    endcase
  end

  // Pad drive decoded from the TX next state so the registered pad pins line up with the phase.
  always_comb begin
    pad_a_n  = 1'b1;
    pad_oe_n = 1'b0;
    case (tx_state_n)
      TX_PRE, TX_STOP: begin
        pad_a_n  = 1'b1;
        pad_oe_n = 1'b1;
      end
      TX_START: begin
        pad_a_n  = 1'b0;
        pad_oe_n = 1'b1;
      end
      TX_DATA: begin
        pad_a_n  = tx_shift_n[0];
        pad_oe_n = 1'b1;
      end
      default: begin
        pad_a_n  = 1'b1;
        pad_oe_n = 1'b0;
      end
    endcase
  end

  // RX next-state: start qualification, mid-bit sampling, stop check and error recovery.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 16'd1;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    err_wait_n = err_wait;
    rx_data_n  = rx_data_r;
    rx_valid_n = 1'b0;
    rx_err_n   = 1'b0;
    if (tx_state != TX_IDLE) begin
      // Our own frame echoes back on PAD_Z; keep the receiver parked.
      rx_state_n = RX_IDLE;
      rx_cnt_n   = 16'd0;
      err_wait_n = 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_cnt_n = 16'd0;
          if (!pad_sync) begin
            rx_state_n = RX_START;
          end else begin
            rx_state_n = RX_IDLE;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt_n = 16'd0;
            if (pad_sync) begin
              rx_state_n = RX_IDLE;
            end else begin
              rx_state_n = RX_DATA;
              rx_bit_n   = 3'd0;
            end
          end else begin
            rx_state_n = RX_START;
          end
        end
        RX_DATA: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt_n   = 16'd0;
            rx_shift_n = {pad_sync, rx_shift[7:1]};
            if (rx_bit == LAST_DATA_BIT) begin
              rx_state_n = RX_STOP;
            end else begin
              rx_bit_n = rx_bit + 3'd1;
            end
          end else begin
            rx_state_n = RX_DATA;
          end
        end
        RX_STOP: begin
          if (err_wait) begin
            // Broken frame: stay out of IDLE until the line is high again,
            // otherwise the low level would be taken as a new start bit.
            rx_cnt_n = 16'd0;
            if (pad_sync) begin
              rx_state_n = RX_IDLE;
              err_wait_n = 1'b0;
            end else begin
              rx_state_n = RX_STOP;
            end
          end else if (rx_cnt == DIV_LAST) begin
            rx_cnt_n = 16'd0;
            if (pad_sync) begin
              rx_state_n = RX_IDLE;
              rx_valid_n = 1'b1;
              rx_data_n  = rx_shift;
            end else begin
              rx_err_n   = 1'b1;
              err_wait_n = 1'b1;
            end
          end else begin
            rx_state_n = RX_STOP;
          end
        end
        default: begin
          rx_state_n = RX_IDLE;
          rx_cnt_n   = 16'd0;
          err_wait_n = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and registered pad/user outputs.
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      ready_en   <= 1'b0;
      tx_state   <= TX_IDLE;
      tx_cnt     <= 16'd0;
      tx_bit     <= 3'd0;
      tx_shift   <= 8'd0;
      rx_state   <= RX_IDLE;
      rx_cnt     <= 16'd0;
      rx_bit     <= 3'd0;
      rx_shift   <= 8'd0;
      err_wait   <= 1'b0;
      rx_data_r  <= 8'd0;
      rx_valid_r <= 1'b0;
      rx_err_r   <= 1'b0;
      PAD_A      <= 1'b1;
      PAD_OUT_EN <= 1'b0;
      PAD_PEN    <= 1'b0;
      PAD_UD_B   <= 1'b1;
      PAD_DS     <= 1'b0;
    end else begin
      ready_en   <= 1'b1;
      tx_state   <= tx_state_n;
      tx_cnt     <= tx_cnt_n;
      tx_bit     <= tx_bit_n;
      tx_shift   <= tx_shift_n;
      rx_state   <= rx_state_n;
      rx_cnt     <= rx_cnt_n;
      rx_bit     <= rx_bit_n;
      rx_shift   <= rx_shift_n;
      err_wait   <= err_wait_n;
      rx_data_r  <= rx_data_n;
      rx_valid_r <= rx_valid_n;
      rx_err_r   <= rx_err_n;
      PAD_A      <= pad_a_n;
      PAD_OUT_EN <= pad_oe_n;
      PAD_PEN    <= cfg_pull_en & ~pad_oe_n;
      PAD_UD_B   <= cfg_pull_up;
      PAD_DS     <= cfg_ds;
    end
  end

endmodule

// File: tb/tb_cern_io_pad_ctrl.sv
// tb_cern_io_pad_ctrl -- scoreboard bench for cern_io_pad_ctrl (CLK_DIV=4, TURN_CYC=2).
// Stimulus pushes expected TX frames / RX results into queues; a negedge monitor
// rebuilds each driven frame from the pad pins and checks it, and checks every
// rx pulse, rx_data hold, pad config registers and reset values.
module tb_cern_io_pad_ctrl;
  import cern_io_pkg::*;

  localparam int D         = 4;
  localparam int T         = 2;
  localparam int FRAME_CYC = T + 10 * D;
  localparam int READY_LAT = 2 * T + 10 * D + 1;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } rx_exp_t;

  logic CLK = 1'b0;
  logic RST_B = 1'b0;
  logic cfg_ds = 1'b0;
  logic cfg_pull_en = 1'b0;
  logic cfg_pull_up = 1'b0;
  logic ext_line = 1'b1;
  logic pad_z;
  logic PAD_A, PAD_OUT_EN, PAD_DS, PAD_PEN, PAD_UD_B;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int t_rxv = 0;
  int last_xfer_cyc = 0;
  bit expect_abort = 1'b0;

  logic [7:0] tx_q[$];
  rx_exp_t    rx_q[$];

  cern_io_pad_ctrl_if bus();

  cern_io_pad_ctrl #(.CLK_DIV(D), .TURN_CYC(T)) dut (
    .CLK         (CLK),
    .RST_B       (RST_B),
    .bus         (bus),
    .cfg_ds      (cfg_ds),
    .cfg_pull_en (cfg_pull_en),
    .cfg_pull_up (cfg_pull_up),
    .PAD_Z       (pad_z),
    .PAD_A       (PAD_A),
    .PAD_OUT_EN  (PAD_OUT_EN),
    .PAD_DS      (PAD_DS),
    .PAD_PEN     (PAD_PEN),
    .PAD_UD_B    (PAD_UD_B)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Open-drain style line: the DUT drives when enabled, otherwise the far end does.
  assign pad_z = PAD_OUT_EN ? PAD_A : ext_line;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Expected pad level at cycle i of a driven frame carrying byte b.
  function automatic logic tx_level(input logic [7:0] b, input int i);
    int k;
    if (i < T) return 1'b1;
    k = (i - T) / D;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Monitor: frame reconstruction, rx scoreboard and per-cycle register checks.
  initial begin : monitor
    logic       rst_prev = 1'b0;
    logic       pen_prev = 1'b0;
    logic       pu_prev = 1'b0;
    logic       ds_prev = 1'b0;
    logic [7:0] last_rx = 8'h00;
    logic       cur[$];
    bit         in_frame = 1'b0;
    rx_exp_t    e;
    logic [7:0] b;
    int         bad;
    forever begin
      @(negedge CLK);
      if (PAD_OUT_EN === 1'b1) begin
        cur.push_back(PAD_A);
        in_frame = 1'b1;
      end else if (in_frame) begin
        in_frame = 1'b0;
        if (expect_abort) begin
          expect_abort = 1'b0;
        end else if (tx_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL tx_unexpected: frame of %0d cycles with none expected", cur.size());
        end else begin
          b = tx_q.pop_front();
          check("tx_frame_len", cur.size(), FRAME_CYC);
          bad = -1;
          for (int i = 0; i < cur.size(); i++)
            if (bad < 0 && cur[i] !== tx_level(b, i)) bad = i;
          n_chk++;
          if (bad >= 0) begin
            n_fail++;
            $display("FAIL tx_frame_bits: byte 0x%02h got level %b at frame cycle %0d, expected %b",
                     b, cur[bad], bad, tx_level(b, bad));
          end
        end
        cur.delete();
      end
      if (!rst_prev) begin
        last_rx = 8'h00;
        check("rst_oe", PAD_OUT_EN, 0);
        check("rst_a", PAD_A, 1);
        check("rst_pen", PAD_PEN, 0);
        check("rst_udb", PAD_UD_B, 1);
        check("rst_ds", PAD_DS, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_rx_err", bus.rx_err, 0);
        check("rst_tx_ready", bus.tx_ready, 0);
      end else begin
        check("pad_pen", PAD_PEN, pen_prev & ~PAD_OUT_EN);
        check("pad_udb", PAD_UD_B, pu_prev);
        check("pad_ds", PAD_DS, ds_prev);
        if (bus.rx_valid === 1'b1 || bus.rx_err === 1'b1) begin
          if (rx_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rx_unexpected: valid=%b err=%b with no frame expected", bus.rx_valid, bus.rx_err);
          end else begin
            e = rx_q.pop_front();
            check("rx_kind", {bus.rx_valid, bus.rx_err}, e.err ? 1 : 2);
            if (!e.err) last_rx = e.data;
            if (bus.rx_valid === 1'b1) t_rxv = cyc;
          end
        end
        check("rx_data", bus.rx_data, last_rx);
      end
      rst_prev = RST_B;
      pen_prev = cfg_pull_en;
      pu_prev  = cfg_pull_up;
      ds_prev  = cfg_ds;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
    if ($urandom_range(7) == 0) begin
      cfg_pull_en = 1'($urandom);
      cfg_pull_up = 1'($urandom);
      cfg_ds      = 1'($urandom);
    end
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge CLK);
      if (bus.tx_ready === 1'b1) seen = 1'b1;
    end
    check("wait_idle", seen, 1);
    @(posedge CLK); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit chk_lat, input bit push);
    bit seen = 1'b0;
    int t0;
    int n = -1;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge CLK);
      if (bus.tx_ready === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL tx_ready_timeout: tx_ready stayed 0 for byte 0x%02h", b);
      bus.tx_valid = 1'b0;
      return;
    end
    t0 = cyc;
    last_xfer_cyc = t0;
    @(posedge CLK); #1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
    if (push) tx_q.push_back(b);
    @(negedge CLK);
    check("tx_oe_start", PAD_OUT_EN, 1);
    if (chk_lat) begin
      for (int i = 0; i < 200; i++) begin
        if (bus.tx_ready === 1'b1) begin
          n = cyc - t0;
          break;
        end
        @(negedge CLK);
      end
      check("tx_ready_latency", n, READY_LAT);
    end
    @(posedge CLK); #1;
  endtask

  task automatic rx_frame(input logic [7:0] b, input bit stop);
    rx_q.push_back('{err: !stop, data: b});
    ext_line = 1'b0;
    repeat (D) tick();
    for (int i = 0; i < 8; i++) begin
      ext_line = b[i];
      repeat (D) tick();
    end
    ext_line = stop;
    repeat (D) tick();
    if (!stop) begin
      ext_line = 1'b0;
      repeat (2 * D) tick();
    end
    ext_line = 1'b1;
    repeat (2 * D) tick();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    RST_B = 1'b0;
    repeat (3) tick();
    RST_B = 1'b1;
    tick();

    send_byte(8'hA5, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1, 1'b1);

    wait_idle();
    rx_frame(8'h3C, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_idle();
      rx_frame(8'($urandom), 1'b1);
    end

    wait_idle();
    rx_frame(8'($urandom), 1'b0);

    // Single-cycle low glitch must be rejected as a false start.
    wait_idle();
    ext_line = 1'b0;
    tick();
    ext_line = 1'b1;
    repeat (3 * D) tick();
    @(negedge CLK);
    check("glitch_rx_idle", bus.tx_ready, 1);
    @(posedge CLK); #1;

    // Transmit request raised in the middle of an incoming frame.
    wait_idle();
    t_rxv = 0;
    fork
      rx_frame(8'($urandom), 1'b1);
      begin
        repeat (3 * D) tick();
        send_byte(8'($urandom), 1'b0, 1'b1);
      end
    join
    check("midrx_rx_seen", t_rxv != 0, 1);
    check("midrx_tx_waits", last_xfer_cyc >= t_rxv, 1);

    // Reset in the data phase of a transmit frame.
    wait_idle();
    expect_abort = 1'b1;
    send_byte(8'($urandom), 1'b0, 1'b0);
    repeat (T + 3 * D) tick();
    @(negedge CLK);
    check("oe_before_rst", PAD_OUT_EN, 1);
    @(posedge CLK); #1;
    RST_B = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("rst_mid_oe", PAD_OUT_EN, 0);
    check("rst_mid_a", PAD_A, 1);
    tick();
    RST_B = 1'b1;
    send_byte(8'h00, 1'b1, 1'b1);

    wait_idle();
    rx_frame(8'($urandom), 1'b1);

    repeat (4 * D) tick();
    check("tx_q_empty", tx_q.size(), 0);
    check("rx_q_empty", rx_q.size(), 0);
    check("abort_consumed", expect_abort, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
